rx_fifo_drain_ctrl: RTL and testbench
=====================================

// Module: rx_fifo_drain_ctrl
// PURPOSE
//   Read-side sequencer for rx_fifo (8-bit, first-word-fall-through). Accepts a burst
//   request of N bytes, pops rx_fifo one byte at a time into a registered valid/ready
//   output stage, and tracks the remaining count. Aborts with a timeout pulse if the
//   FIFO stays empty too long. Sits between rx_fifo and the host-side bus interface.
// PARAMETERS
//   LEN_W           7     width of req_len / remaining count (max burst 2**LEN_W-1)
//   TIMEOUT_CYCLES  256   consecutive starved cycles in XFER before abort (>=2)
// PORTS
//   clk            in   1      system clock (96 MHz)
//   n_rst          in   1      asynchronous active-low reset
//   req            in   1      burst request; sampled only in IDLE
//   req_len        in   LEN_W  bytes to transfer; latched with req
//   fifo_empty     in   1      rx_fifo empty flag
//   fifo_rdata     in   8      rx_fifo head byte, valid while !fifo_empty
//   fifo_r_enable  out  1      rx_fifo pop strobe (combinational)
//   out_data       out  8      registered output byte
//   out_valid      out  1      out_data valid
//   out_ready      in   1      consumer accepts out_data when out_valid & out_ready
//   busy           out  1      high in any state other than IDLE
//   done           out  1      1-cycle pulse: burst completed normally
//   timeout        out  1      1-cycle pulse: burst aborted on starvation
//   remaining      out  LEN_W  bytes still to pop in current burst
// BEHAVIOUR
//   Reset: state=IDLE; out_data=0, out_valid=0, remaining=0, wait_cnt=0, done=0,
//     timeout=0; fifo_r_enable=0 (combinational from reset-state regs).
//   States: IDLE, XFER, FLUSH.
//   IDLE: req=1 -> remaining<=req_len, wait_cnt<=0, go XFER. req_len=0 -> go FLUSH
//     directly (done pulses one cycle later, no pops). req ignored outside IDLE.
//   pop = (state==XFER) & (remaining!=0) & !fifo_empty & (!out_valid | out_ready).
//   fifo_r_enable = pop. On pop: out_data<=fifo_rdata, out_valid<=1, remaining-=1,
//     wait_cnt<=0. Output latency: byte appears on out_data 1 cycle after pop.
//   No pop & out_valid & out_ready -> out_valid<=0. Pop with concurrent accept keeps
//     out_valid=1 (back-to-back, one byte per cycle sustained).
//   out_data held stable while out_valid & !out_ready; never popped over.
//   XFER, remaining==0 -> go FLUSH (transition on the cycle after last pop).
//   XFER starvation: fifo_empty & remaining!=0 -> wait_cnt+=1; out_ready stalls do
//     not count. wait_cnt reaching TIMEOUT_CYCLES-1 while still starved -> set abort
//     flag, go FLUSH; remaining holds the unsent count.
//   FLUSH: wait until out_valid==0 (pending byte accepted), then go IDLE and pulse
//     done (normal) or timeout (abort) for exactly one cycle on IDLE entry.
//   done and timeout never assert together; busy=0 on the pulse cycle.
//   Reset mid-burst: immediate return to IDLE, pending out byte discarded; FIFO
//     contents untouched (no pops during or after reset).
// TESTING
//   1 Reset: n_rst=0 mid-XFER -> out_valid=0, busy=0, fifo_r_enable=0 same cycle.
//   2 FIFO preloaded 0x00..0x07, req_len=8, out_ready=1 -> 8 pops on consecutive
//     cycles, out_data 0x00..0x07 back-to-back, done pulse, fifo_empty=1, remaining=0.
//   3 Same with out_ready toggling 1/0 -> no byte lost or duplicated, out_data stable
//     while stalled, fifo_r_enable never high while out_valid & !out_ready.
//   4 FIFO holds 3 bytes, req_len=5, TIMEOUT_CYCLES=16 -> 3 bytes delivered, timeout
//     pulse 16 cycles after last pop (plus flush), remaining=2, done never asserts.
//   5 req_len=0 -> no pops, done pulses 2 cycles after req; req during busy ignored.
//   6 FIFO initially empty, bytes 0xFF,0x00 written after 5 cycles, req_len=2 ->
//     both delivered in order, wait_cnt cleared, done pulse, no timeout.

Source files
------------

// File: rtl/rx_fifo_drain_ctrl.sv
// Read-side sequencer for a first-word-fall-through rx_fifo: drains an N-byte burst
// into a registered valid/ready stage and aborts if the FIFO starves for too long.
module rx_fifo_drain_ctrl #(
  parameter int LEN_W          = 7,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req,
  input  logic [LEN_W-1:0] req_len,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_r_enable,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [LEN_W-1:0] remaining
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_FLUSH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              abort;
  logic              pop;
  logic              starved;
  logic              accept;
  logic              start;
  logic              flush_exit;

  assign accept     = out_valid & out_ready;
  assign start      = (state == S_IDLE) & req;
  assign pop        = (state == S_XFER) & (remaining != '0) & ~fifo_empty
                    & (~out_valid | out_ready);
  assign starved    = (state == S_XFER) & (remaining != '0) & fifo_empty;
  assign flush_exit = (state == S_FLUSH) & ~out_valid;

  assign fifo_r_enable = pop;
  assign busy          = (state != S_IDLE);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = (req_len == '0) ? S_FLUSH : S_XFER;
        end
      end
      S_XFER: begin
        if (remaining == '0) begin
          state_nxt = S_FLUSH;
        end else if (starved && (wait_cnt == WAIT_LAST)) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!out_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output stage: a pop refills it (even on the accept cycle), otherwise an accept empties it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_data  <= fifo_rdata;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      remaining <= '0;
      wait_cnt  <= '0;
      abort     <= 1'b0;
    end else if (start) begin
      remaining <= req_len;
      wait_cnt  <= '0;
      abort     <= 1'b0;
    end else if (pop) begin
      remaining <= remaining - LEN_W'(1);
      wait_cnt  <= '0;
    end else if (starved) begin
      // The last starved cycle raises abort instead of wrapping the counter.
      if (wait_cnt == WAIT_LAST) begin
        abort <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= flush_exit & ~abort;
      timeout <= flush_exit & abort;
    end
  end

endmodule

// File: tb/tb_rx_fifo_drain_ctrl.sv
// Directed bench for rx_fifo_drain_ctrl: a behavioural FWFT FIFO feeds the DUT and
// each scenario task compares outputs against hand-computed cycle-exact expectations.
module tb_rx_fifo_drain_ctrl;
  localparam int LEN_W = 7;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             req = 1'b0;
  logic [LEN_W-1:0] req_len = '0;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic             fifo_r_enable;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [LEN_W-1:0] remaining;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic [7:0] got [512];
  int         n_got = 0;
  int         stall_pop_viol = 0;
  int         stable_viol = 0;
  int         stall_cycles = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  rx_fifo_drain_ctrl #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_len(req_len),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_r_enable(fifo_r_enable),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .timeout(timeout), .remaining(remaining)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr[7:0]];

  // FIFO pop, accepted-byte scoreboard and handshake-rule monitors on the active edge.
  always @(posedge clk) begin
    if (fifo_r_enable && !fifo_empty) rd_ptr <= rd_ptr + 1;
    if (out_valid && out_ready) begin
      got[n_got] <= out_data;
      n_got      <= n_got + 1;
    end
    if (fifo_r_enable && out_valid && !out_ready) stall_pop_viol <= stall_pop_viol + 1;
    if (out_valid && !out_ready) stall_cycles <= stall_cycles + 1;
    if (n_rst && prev_stall && (!out_valid || out_data !== prev_data)) stable_viol <= stable_viol + 1;
    prev_stall <= out_valid && !out_ready;
    prev_data  <= out_data;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Runs a fixed number of cycles, cycle 0 being the one currently sampled.
  task automatic run_cycles(input int ncyc, input bit toggle, output int first_done,
                            output int first_tmo, output int n_done, output int n_tmo,
                            output int n_pop);
    first_done = -1; first_tmo = -1; n_done = 0; n_tmo = 0; n_pop = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (toggle) out_ready = (c % 2 == 1);
      #1;
      if (done) begin n_done++; if (first_done < 0) first_done = c; end
      if (timeout) begin n_tmo++; if (first_tmo < 0) first_tmo = c; end
      if (fifo_r_enable) n_pop++;
      step();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (remaining !== 7'd0) begin errors++; $display("FAIL reset_remaining: got %0d want 0", remaining); end
    checks++; if ({done, timeout, fifo_r_enable} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {done, timeout, fifo_r_enable}); end
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_burst();
    int base;
    for (int i = 0; i < 8; i++) push(8'(i));
    out_ready = 1'b1; req_len = 7'd8; req = 1'b1;
    step();
    req = 1'b0;
    base = n_got;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (fifo_r_enable !== 1'b1) begin errors++; $display("FAIL burst_pop[%0d]: got %b want 1", i, fifo_r_enable); end
      checks++; if (remaining !== 7'(8 - i)) begin errors++; $display("FAIL burst_remaining[%0d]: got %0d want %0d", i, remaining, 8 - i); end
      if (i > 0) begin
        checks++; if ({out_valid, out_data} !== {1'b1, 8'(i - 1)}) begin errors++; $display("FAIL burst_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 8'(i - 1)); end
      end
      step();
    end
    checks++; if ({fifo_r_enable, out_valid, out_data, remaining} !== {1'b0, 1'b1, 8'h07, 7'd0}) begin errors++; $display("FAIL burst_last: got en=%b v=%b d=%h rem=%0d want en=0 v=1 d=07 rem=0", fifo_r_enable, out_valid, out_data, remaining); end
    step();
    checks++; if ({out_valid, done, busy} !== 3'b001) begin errors++; $display("FAIL burst_flush: got v/done/busy=%b want 001", {out_valid, done, busy}); end
    step();
    checks++; if ({done, timeout, busy} !== 3'b100) begin errors++; $display("FAIL burst_done: got done/tmo/busy=%b want 100", {done, timeout, busy}); end
    checks++; if ({fifo_empty, remaining} !== {1'b1, 7'd0}) begin errors++; $display("FAIL burst_end_state: got empty=%b rem=%0d want empty=1 rem=0", fifo_empty, remaining); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL burst_done_width: got %b want 0", done); end
    checks++; if (n_got - base !== 8) begin errors++; $display("FAIL burst_count: got %0d want 8", n_got - base); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[base + i] !== 8'(i)) begin errors++; $display("FAIL burst_byte[%0d]: got %h want %h", i, got[base + i], 8'(i)); end
    end
  endtask

  task automatic test_stall();
    int base, fd, ft, nd, nt, np, viol0, stab0, stall0;
    viol0 = stall_pop_viol; stab0 = stable_viol; stall0 = stall_cycles;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    out_ready = 1'b0; req_len = 7'd8; req = 1'b1;
    step();
    req = 1'b0;
    base = n_got;
    run_cycles(40, 1'b1, fd, ft, nd, nt, np);
    checks++; if ({nd, nt, np} !== {32'd1, 32'd0, 32'd8}) begin errors++; $display("FAIL stall_counts: got done=%0d tmo=%0d pops=%0d want 1 0 8", nd, nt, np); end
    checks++; if (stall_cycles == stall0) begin errors++; $display("FAIL stall_exercised: got %0d stall cycles want >0", stall_cycles - stall0); end
    checks++; if (stall_pop_viol !== viol0) begin errors++; $display("FAIL stall_pop_over: got %0d pops under stall want 0", stall_pop_viol - viol0); end
    checks++; if (stable_viol !== stab0) begin errors++; $display("FAIL stall_stable: got %0d data changes under stall want 0", stable_viol - stab0); end
    checks++; if (n_got - base !== 8) begin errors++; $display("FAIL stall_count: got %0d want 8", n_got - base); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[base + i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL stall_byte[%0d]: got %h want %h", i, got[base + i], 8'h10 + 8'(i)); end
    end
    checks++; if ({fifo_empty, remaining, busy} !== {1'b1, 7'd0, 1'b0}) begin errors++; $display("FAIL stall_end_state: got empty=%b rem=%0d busy=%b want 1 0 0", fifo_empty, remaining, busy); end
  endtask

  task automatic test_timeout();
    int base, fd, ft, nd, nt, np;
    push(8'hA0); push(8'hA1); push(8'hA2);
    out_ready = 1'b1; req_len = 7'd5; req = 1'b1;
    step();
    req = 1'b0;
    base = n_got;
    // Pops at cycles 0..2, 16 starved cycles 3..18, FLUSH at 19, pulse at 20.
    run_cycles(26, 1'b0, fd, ft, nd, nt, np);
    checks++; if (ft !== 20) begin errors++; $display("FAIL tmo_cycle: got %0d want 20", ft); end
    checks++; if ({nt, nd, np} !== {32'd1, 32'd0, 32'd3}) begin errors++; $display("FAIL tmo_counts: got tmo=%0d done=%0d pops=%0d want 1 0 3", nt, nd, np); end
    checks++; if ({remaining, busy} !== {7'd2, 1'b0}) begin errors++; $display("FAIL tmo_remaining: got rem=%0d busy=%b want rem=2 busy=0", remaining, busy); end
    checks++; if ({got[base], got[base + 1], got[base + 2]} !== 24'hA0A1A2 || n_got - base !== 3) begin errors++; $display("FAIL tmo_bytes: got %h%h%h n=%0d want a0a1a2 n=3", got[base], got[base + 1], got[base + 2], n_got - base); end
  endtask

  task automatic test_zero_len();
    int lvl;
    push(8'h55);
    lvl = wr_ptr - rd_ptr;
    req_len = 7'd0; req = 1'b1;
    step();
    checks++; if ({busy, fifo_r_enable, done} !== 3'b100) begin errors++; $display("FAIL zero_flush: got busy/en/done=%b want 100", {busy, fifo_r_enable, done}); end
    req_len = 7'd3;
    step();
    checks++; if ({done, busy, timeout} !== 3'b100) begin errors++; $display("FAIL zero_done: got done/busy/tmo=%b want 100", {done, busy, timeout}); end
    checks++; if (remaining !== 7'd0) begin errors++; $display("FAIL zero_req_ignored: got rem=%0d want 0", remaining); end
    req = 1'b0;
    step();
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL zero_after: got done/busy=%b want 00", {done, busy}); end
    checks++; if (wr_ptr - rd_ptr !== lvl) begin errors++; $display("FAIL zero_no_pop: got level %0d want %0d", wr_ptr - rd_ptr, lvl); end
    wr_ptr = rd_ptr;
    step();
  endtask

  task automatic test_starve_resume();
    int base, first_done, n_tmo, n_pop;
    int pop_at [2];
    first_done = -1; n_tmo = 0; n_pop = 0; pop_at[0] = -1; pop_at[1] = -1;
    out_ready = 1'b1; req_len = 7'd2; req = 1'b1;
    step();
    req = 1'b0;
    base = n_got;
    // 5 + 12 starved cycles exceed TMO only if the pop failed to clear the counter.
    for (int c = 0; c < 30; c++) begin
      if (c == 5) push(8'hFF);
      if (c == 18) push(8'h00);
      #1;
      if (fifo_r_enable) begin if (n_pop < 2) pop_at[n_pop] = c; n_pop++; end
      if (done && first_done < 0) first_done = c;
      if (timeout) n_tmo++;
      step();
    end
    checks++; if ({pop_at[0], pop_at[1], n_pop} !== {32'd5, 32'd18, 32'd2}) begin errors++; $display("FAIL resume_pops: got %0d,%0d n=%0d want 5,18 n=2", pop_at[0], pop_at[1], n_pop); end
    checks++; if (first_done !== 21) begin errors++; $display("FAIL resume_done: got cycle %0d want 21", first_done); end
    checks++; if (n_tmo !== 0) begin errors++; $display("FAIL resume_no_tmo: got %0d want 0", n_tmo); end
    checks++; if ({got[base], got[base + 1]} !== 16'hFF00 || n_got - base !== 2) begin errors++; $display("FAIL resume_bytes: got %h%h n=%0d want ff00 n=2", got[base], got[base + 1], n_got - base); end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    out_ready = 1'b0; req_len = 7'd4; req = 1'b1;
    step();
    req = 1'b0;
    checks++; if (fifo_r_enable !== 1'b1) begin errors++; $display("FAIL rst_first_pop: got %b want 1", fifo_r_enable); end
    step();
    checks++; if ({out_valid, fifo_r_enable, busy} !== 3'b101) begin errors++; $display("FAIL rst_pre_state: got v/en/busy=%b want 101", {out_valid, fifo_r_enable, busy}); end
    n_rst = 1'b0;
    #1;
    checks++; if ({out_valid, busy, fifo_r_enable} !== 3'b000) begin errors++; $display("FAIL rst_same_cycle: got v/busy/en=%b want 000", {out_valid, busy, fifo_r_enable}); end
    checks++; if ({out_data, remaining} !== {8'h00, 7'd0}) begin errors++; $display("FAIL rst_regs: got d=%h rem=%0d want 00 0", out_data, remaining); end
    step(); step();
    n_rst = 1'b1;
    step();
    checks++; if ({busy, out_valid, fifo_r_enable} !== 3'b000) begin errors++; $display("FAIL rst_after: got busy/v/en=%b want 000", {busy, out_valid, fifo_r_enable}); end
    checks++; if (wr_ptr - rd_ptr !== 3) begin errors++; $display("FAIL rst_fifo_untouched: got level %0d want 3", wr_ptr - rd_ptr); end
  endtask

  task automatic test_back_to_back();
    int base;
    out_ready = 1'b1; req_len = 7'd3; req = 1'b1;
    step();
    req = 1'b0;
    base = n_got;
    checks++; if (remaining !== 7'd3) begin errors++; $display("FAIL b2b_len: got %0d want 3", remaining); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (fifo_r_enable !== (c < 3)) begin errors++; $display("FAIL b2b_pop[%0d]: got %b want %b", c, fifo_r_enable, c < 3); end
      step();
    end
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL b2b_done1: got done/busy=%b want 10", {done, busy}); end
    push(8'h40); req_len = 7'd1; req = 1'b1;
    step();
    req = 1'b0;
    checks++; if ({fifo_r_enable, remaining} !== {1'b1, 7'd1}) begin errors++; $display("FAIL b2b_restart: got en=%b rem=%0d want 1 1", fifo_r_enable, remaining); end
    step(); step(); step();
    checks++; if ({done, timeout, busy} !== 3'b100) begin errors++; $display("FAIL b2b_done2: got done/tmo/busy=%b want 100", {done, timeout, busy}); end
    checks++; if ({got[base], got[base + 1], got[base + 2], got[base + 3]} !== 32'h31323340 || n_got - base !== 4) begin errors++; $display("FAIL b2b_bytes: got %h%h%h%h n=%0d want 31323340 n=4", got[base], got[base + 1], got[base + 2], got[base + 3], n_got - base); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_stall();
    test_timeout();
    test_zero_len();
    test_starve_resume();
    test_reset_mid_burst();
    test_back_to_back();
    checks++; if (stall_pop_viol !== 0) begin errors++; $display("FAIL global_pop_under_stall: got %0d want 0", stall_pop_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
